// File: rtl/regbus2axi4lite.sv
// Bridges single regbus read/write requests onto an AXI4-Lite master port, one outstanding at a time.
// Latency: request in cycle N, completion pulse at N+3 with a zero-wait slave; timeout aborts after TIMEOUT_CYC busy cycles.
// Backpressure: requests while busy, or coincident with the completion pulse, are dropped; AXI valids hold until handshake.
module regbus2axi4lite #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic                addr_valid,
    input  logic                reg_write,
    input  logic [ADDR_W-1:0]   reg_addr,
    input  logic [DATA_W-1:0]   reg_wdata,
    output logic                reg_ready,
    output logic [DATA_W-1:0]   reg_rdata,
    output logic                reg_error,
    output logic                reg_busy,
    output logic [ADDR_W-1:0]   M_AXI_AWADDR,
    output logic [2:0]          M_AXI_AWPROT,
    output logic                M_AXI_AWVALID,
    input  logic                M_AXI_AWREADY,
    output logic [DATA_W-1:0]   M_AXI_WDATA,
    output logic [DATA_W/8-1:0] M_AXI_WSTRB,
    output logic                M_AXI_WVALID,
    input  logic                M_AXI_WREADY,
    input  logic [1:0]          M_AXI_BRESP,
    input  logic                M_AXI_BVALID,
    output logic                M_AXI_BREADY,
    output logic [ADDR_W-1:0]   M_AXI_ARADDR,
    output logic [2:0]          M_AXI_ARPROT,
    output logic                M_AXI_ARVALID,
    input  logic                M_AXI_ARREADY,
    input  logic [DATA_W-1:0]   M_AXI_RDATA,
    input  logic [1:0]          M_AXI_RRESP,
    input  logic                M_AXI_RVALID,
    output logic                M_AXI_RREADY
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] WR_REQ  = 3'd1;
    localparam logic [2:0] WR_RESP = 3'd2;
    localparam logic [2:0] RD_REQ  = 3'd3;
    localparam logic [2:0] RD_RESP = 3'd4;

    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [2:0]        state;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              awvalid_q;
    logic              wvalid_q;
    logic              arvalid_q;
    logic              aw_done;
    logic              w_done;
    logic [CNT_W-1:0]  to_cnt;
    logic              timeout_hit;
    logic              aw_hs;
    logic              w_hs;

    assign timeout_hit = (TIMEOUT_CYC != 0) && (to_cnt == CNT_W'(TIMEOUT_CYC - 1));
    assign aw_hs       = awvalid_q && M_AXI_AWREADY;
    assign w_hs        = wvalid_q && M_AXI_WREADY;

    assign reg_busy      = (state != IDLE);
    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_WSTRB   = '1;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_ARVALID = arvalid_q;
    // Readies decode straight from state so reset drops them asynchronously.
    assign M_AXI_BREADY  = (state == WR_RESP);
    assign M_AXI_RREADY  = (state == RD_RESP);

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            to_cnt <= '0;
        end else if (state == IDLE) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state     <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            arvalid_q <= 1'b0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            reg_ready <= 1'b0;
            reg_error <= 1'b0;
            reg_rdata <= '0;
        end else begin
            reg_ready <= 1'b0;
            reg_error <= 1'b0;
            if (state != IDLE && timeout_hit) begin
                // Abort: the slave may be wedged, so nothing is left dangling on the bus.
                awvalid_q <= 1'b0;
                wvalid_q  <= 1'b0;
                arvalid_q <= 1'b0;
                state     <= IDLE;
                reg_ready <= 1'b1;
                reg_error <= 1'b1;
                reg_rdata <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (addr_valid && !reg_ready) begin
                            addr_q  <= reg_addr;
                            wdata_q <= reg_wdata;
                            aw_done <= 1'b0;
                            w_done  <= 1'b0;
                            if (reg_write) begin
                                state     <= WR_REQ;
                                awvalid_q <= 1'b1;
                                wvalid_q  <= 1'b1;
                            end else begin
                                state     <= RD_REQ;
                                arvalid_q <= 1'b1;
                            end
                        end
                    end
                    WR_REQ: begin
                        if (aw_hs) begin
                            awvalid_q <= 1'b0;
                            aw_done   <= 1'b1;
                        end
                        if (w_hs) begin
                            wvalid_q <= 1'b0;
                            w_done   <= 1'b1;
                        end
                        if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                            state <= WR_RESP;
                        end
                    end
                    WR_RESP: begin
                        if (M_AXI_BVALID) begin
                            state     <= IDLE;
                            reg_ready <= 1'b1;
                            reg_error <= (M_AXI_BRESP != 2'b00);
                        end
                    end
                    RD_REQ: begin
                        if (M_AXI_ARREADY) begin
                            arvalid_q <= 1'b0;
                            state     <= RD_RESP;
                        end
                    end
                    RD_RESP: begin
                        if (M_AXI_RVALID) begin
                            state     <= IDLE;
                            reg_ready <= 1'b1;
                            reg_rdata <= M_AXI_RDATA;
                            reg_error <= (M_AXI_RRESP != 2'b00);
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_regbus2axi4lite.sv
// Directed bench for regbus2axi4lite: zero-wait and stalled writes, error reads, timeout, busy drops, async reset.
module tb_regbus2axi4lite;

    logic        Clk;
    logic        Rst;
    logic        addr_valid;
    logic        reg_write;
    logic [31:0] reg_addr;
    logic [31:0] reg_wdata;
    logic        reg_ready;
    logic [31:0] reg_rdata;
    logic        reg_error;
    logic        reg_busy;
    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    int total = 0;
    int bad   = 0;

    regbus2axi4lite #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(16)) dut (
        .Clk(Clk), .Rst(Rst),
        .addr_valid(addr_valid), .reg_write(reg_write), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
        .reg_ready(reg_ready), .reg_rdata(reg_rdata), .reg_error(reg_error), .reg_busy(reg_busy),
        .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
        .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
        .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
        .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
        .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
    task automatic nxt();
        @(posedge Clk);
        #1;
    endtask

    task automatic smp();
        @(negedge Clk);
    endtask

    task automatic idle_slave();
        awready = 0; wready = 0; bvalid = 0; bresp = 0;
        arready = 0; rvalid = 0; rresp = 0; rdata = 0;
    endtask

    task automatic test_reset();
        Rst = 1; addr_valid = 0; reg_write = 0; reg_addr = 0; reg_wdata = 0;
        idle_slave();
        nxt(); nxt();
        smp();
        total++; if ({reg_ready, reg_error, reg_busy, awvalid, wvalid, arvalid, bready, rready} !== 8'h00) begin bad++; $display("FAIL reset_ctrl got=%b exp=00000000", {reg_ready, reg_error, reg_busy, awvalid, wvalid, arvalid, bready, rready}); end
        total++; if (reg_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", reg_rdata); end
        total++; if ({awprot, arprot, wstrb} !== 10'b000_000_1111) begin bad++; $display("FAIL reset_prot_strb got=%b exp=0000001111", {awprot, arprot, wstrb}); end
        nxt();
        Rst = 0;
        nxt();
    endtask

    task automatic test_write_zero_wait();
        addr_valid = 1; reg_write = 1; reg_addr = 32'h40; reg_wdata = 32'hDEADBEEF;
        awready = 1; wready = 1;
        smp();
        total++; if (reg_busy !== 1'b0) begin bad++; $display("FAIL wr0_busy_n got=%b exp=0", reg_busy); end
        nxt(); addr_valid = 0;
        smp();
        total++; if ({awvalid, wvalid, reg_busy} !== 3'b111) begin bad++; $display("FAIL wr0_valid_n1 got=%b exp=111", {awvalid, wvalid, reg_busy}); end
        total++; if (awaddr !== 32'h40 || wdata !== 32'hDEADBEEF) begin bad++; $display("FAIL wr0_addr_data got=%h/%h exp=00000040/deadbeef", awaddr, wdata); end
        nxt(); bvalid = 1; bresp = 2'b00;
        smp();
        total++; if ({awvalid, wvalid, bready} !== 3'b001) begin bad++; $display("FAIL wr0_bready_n2 got=%b exp=001", {awvalid, wvalid, bready}); end
        nxt(); bvalid = 0;
        smp();
        total++; if ({reg_ready, reg_error, reg_busy, bready} !== 4'b1000) begin bad++; $display("FAIL wr0_done_n3 got=%b exp=1000", {reg_ready, reg_error, reg_busy, bready}); end
        nxt(); idle_slave();
        smp();
        total++; if (reg_ready !== 1'b0) begin bad++; $display("FAIL wr0_pulse_width got=%b exp=0", reg_ready); end
        nxt();
    endtask

    task automatic test_write_stall();
        int ready_cnt = 0;
        addr_valid = 1; reg_write = 1; reg_addr = 32'h44; reg_wdata = 32'hCAFE0001;
        nxt(); addr_valid = 0; reg_wdata = 32'h0; awready = 1;
        smp();
        total++; if ({awvalid, wvalid} !== 2'b11) begin bad++; $display("FAIL wrs_n1 got=%b exp=11", {awvalid, wvalid}); end
        nxt(); awready = 0;
        smp();
        total++; if ({awvalid, wvalid} !== 2'b01 || wdata !== 32'hCAFE0001) begin bad++; $display("FAIL wrs_n2 got=%b/%h exp=01/cafe0001", {awvalid, wvalid}, wdata); end
        nxt();
        smp();
        total++; if (wvalid !== 1'b1 || wdata !== 32'hCAFE0001) begin bad++; $display("FAIL wrs_n3 got=%b/%h exp=1/cafe0001", wvalid, wdata); end
        nxt(); wready = 1;
        smp();
        total++; if (wvalid !== 1'b1 || bready !== 1'b0) begin bad++; $display("FAIL wrs_n4 got=%b%b exp=10", wvalid, bready); end
        nxt(); wready = 0; bvalid = 1;
        smp();
        total++; if ({wvalid, bready} !== 2'b01) begin bad++; $display("FAIL wrs_n5 got=%b exp=01", {wvalid, bready}); end
        nxt(); bvalid = 0;
        for (int i = 0; i < 5; i++) begin
            smp();
            if (reg_ready === 1'b1) ready_cnt++;
            nxt();
        end
        total++; if (ready_cnt !== 1) begin bad++; $display("FAIL wrs_ready_count got=%0d exp=1", ready_cnt); end
        idle_slave();
    endtask

    task automatic test_read_slverr();
        addr_valid = 1; reg_write = 0; reg_addr = 32'h10; arready = 1;
        nxt(); addr_valid = 0;
        smp();
        total++; if (arvalid !== 1'b1 || araddr !== 32'h10) begin bad++; $display("FAIL rd_ar got=%b/%h exp=1/00000010", arvalid, araddr); end
        nxt();
        smp();
        total++; if ({arvalid, rready, reg_ready} !== 3'b010) begin bad++; $display("FAIL rd_rready got=%b exp=010", {arvalid, rready, reg_ready}); end
        nxt(); nxt();
        nxt(); rvalid = 1; rdata = 32'h12345678; rresp = 2'b10;
        nxt(); rvalid = 0; rdata = 32'h0;
        smp();
        total++; if ({reg_ready, reg_error} !== 2'b11 || reg_rdata !== 32'h12345678) begin bad++; $display("FAIL rd_slverr got=%b/%h exp=11/12345678", {reg_ready, reg_error}, reg_rdata); end
        nxt(); idle_slave();
    endtask

    task automatic test_timeout();
        int high_cnt = 0;
        addr_valid = 1; reg_write = 1; reg_addr = 32'h60; reg_wdata = 32'h5555AAAA;
        nxt(); addr_valid = 0;
        for (int i = 0; i < 16; i++) begin
            smp();
            if (awvalid === 1'b1 && wvalid === 1'b1) high_cnt++;
            nxt();
        end
        smp();
        total++; if (high_cnt !== 16) begin bad++; $display("FAIL to_valid_cycles got=%0d exp=16", high_cnt); end
        total++; if ({awvalid, wvalid, reg_ready, reg_error, reg_busy} !== 5'b00110) begin bad++; $display("FAIL to_abort got=%b exp=00110", {awvalid, wvalid, reg_ready, reg_error, reg_busy}); end
        total++; if (reg_rdata !== 32'h0) begin bad++; $display("FAIL to_rdata got=%h exp=0", reg_rdata); end
        nxt();
    endtask

    task automatic test_back_to_back();
        int ar_cnt = 0;
        int rdy_cnt = 0;
        addr_valid = 1; reg_write = 0; reg_addr = 32'h20; arready = 1;
        smp(); if (arvalid && arready) ar_cnt++;
        nxt(); reg_write = 1; reg_addr = 32'h80;
        smp(); if (arvalid && arready) ar_cnt++;
        nxt(); addr_valid = 0; rvalid = 1; rdata = 32'h0000A5A5;
        smp(); if (arvalid && arready) ar_cnt++;
        total++; if (awvalid !== 1'b0) begin bad++; $display("FAIL b2b_busy_ignored got=%b exp=0", awvalid); end
        nxt(); rvalid = 0; addr_valid = 1; reg_write = 0; reg_addr = 32'h90;
        smp(); if (reg_ready) rdy_cnt++;
        total++; if (reg_rdata !== 32'h0000A5A5) begin bad++; $display("FAIL b2b_rdata1 got=%h exp=0000a5a5", reg_rdata); end
        total++; if (ar_cnt !== 1 || rdy_cnt !== 1) begin bad++; $display("FAIL b2b_counts got=%0d/%0d exp=1/1", ar_cnt, rdy_cnt); end
        nxt(); reg_addr = 32'h30;
        smp();
        total++; if ({reg_busy, arvalid, reg_ready} !== 3'b000) begin bad++; $display("FAIL b2b_coincident_ignored got=%b exp=000", {reg_busy, arvalid, reg_ready}); end
        nxt(); addr_valid = 0;
        smp();
        total++; if (arvalid !== 1'b1 || araddr !== 32'h30) begin bad++; $display("FAIL b2b_next_ar got=%b/%h exp=1/00000030", arvalid, araddr); end
        nxt(); rvalid = 1; rdata = 32'h0BADF00D; rresp = 2'b00;
        nxt(); rvalid = 0;
        smp();
        total++; if ({reg_ready, reg_error} !== 2'b10 || reg_rdata !== 32'h0BADF00D) begin bad++; $display("FAIL b2b_rd2 got=%b/%h exp=10/0badf00d", {reg_ready, reg_error}, reg_rdata); end
        nxt(); idle_slave();
    endtask

    task automatic test_reset_mid();
        int rdy_cnt = 0;
        addr_valid = 1; reg_write = 0; reg_addr = 32'h50;
        nxt(); addr_valid = 0;
        total++; if (arvalid !== 1'b1) begin bad++; $display("FAIL rst_mid_arvalid got=%b exp=1", arvalid); end
        #1 Rst = 1;
        #1;
        total++; if ({arvalid, rready, bready, awvalid, wvalid, reg_ready, reg_busy} !== 7'b0) begin bad++; $display("FAIL rst_mid_async got=%b exp=0000000", {arvalid, rready, bready, awvalid, wvalid, reg_ready, reg_busy}); end
        nxt(); Rst = 0;
        for (int i = 0; i < 4; i++) begin
            smp();
            if (reg_ready || reg_busy) rdy_cnt++;
            nxt();
        end
        total++; if (rdy_cnt !== 0) begin bad++; $display("FAIL rst_mid_no_pulse got=%0d exp=0", rdy_cnt); end
        addr_valid = 1; reg_addr = 32'h44; arready = 1;
        nxt(); addr_valid = 0;
        smp();
        total++; if (arvalid !== 1'b1 || araddr !== 32'h44) begin bad++; $display("FAIL rst_mid_ar got=%b/%h exp=1/00000044", arvalid, araddr); end
        nxt(); rvalid = 1; rdata = 32'h00000077;
        nxt(); rvalid = 0;
        smp();
        total++; if ({reg_ready, reg_error} !== 2'b10 || reg_rdata !== 32'h77) begin bad++; $display("FAIL rst_mid_recover got=%b/%h exp=10/00000077", {reg_ready, reg_error}, reg_rdata); end
        nxt(); idle_slave();
    endtask

    initial begin
        test_reset();
        test_write_zero_wait();
        test_write_stall();
        test_read_slverr();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
